// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls,
// data-memory wait freeze, mult/div occupancy and control-flow flushes.
module hazard_ctrl #(
    parameter int MD_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_is_branch,
    input  logic       id_is_j,
    input  logic       id_is_jr,
    input  logic       comp_true,
    input  logic       id_md_start,
    input  logic       id_md_use,
    input  logic       idex_memread,
    input  logic       idex_regwrite,
    input  logic [4:0] idex_dst,
    input  logic       exmem_memop,
    input  logic       dmem_ready,
    output logic [1:0] IFIDop,
    output logic [1:0] IDEXop,
    output logic [1:0] EXMEMop,
    output logic [1:0] PCSrc,
    output logic       md_busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        MD_BUSY = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADV  = 2'd0;
    localparam logic [1:0] OP_BUB  = 2'd1;
    localparam logic [1:0] OP_HOLD = 2'd2;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_J   = 2'd2;
    localparam logic [1:0] PC_JR  = 2'd3;

    localparam logic [5:0] MD_INIT = 6'(MD_LAT - 1);

    state_t     state, state_nxt;
    logic [1:0] st_cnt, st_nxt;
    logic [5:0] md_cnt, md_nxt;

    logic [1:0] ifid_c, idex_c, exmem_c, pc_c;

    logic hit;
    logic memwait;
    logic br_or_jr;
    logic ld_haz;
    logic alu_haz;
    logic data_haz;
    logic md_haz;
    logic [1:0] st_load;

    assign hit = (idex_dst != 5'd0) &&
                 ((id_uses_rs && (id_rs == idex_dst)) ||
                  (id_uses_rt && (id_rt == idex_dst)));

    assign memwait  = exmem_memop && !dmem_ready;
    assign br_or_jr = id_is_branch || id_is_jr;

    assign ld_haz  = (state == RUN) && idex_memread && hit;
    assign alu_haz = (state == RUN) && idex_regwrite &&
                     !idex_memread && hit && br_or_jr;
    assign data_haz = ld_haz || alu_haz;

    // A load feeding a branch/jr needs a second bubble for the compare.
    assign st_load = (ld_haz && br_or_jr) ? 2'd1 : 2'd0;

    assign md_haz = (state == MD_BUSY) && id_md_use &&
                    (md_cnt > 6'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            st_cnt <= 2'd0;
            md_cnt <= 6'd0;
        end else begin
            state  <= state_nxt;
            st_cnt <= st_nxt;
            md_cnt <= md_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        st_nxt    = st_cnt;
        md_nxt    = md_cnt;
        ifid_c    = OP_ADV;
        idex_c    = OP_ADV;
        exmem_c   = OP_ADV;
        pc_c      = PC_SEQ;

        if (memwait) begin
            ifid_c  = OP_HOLD;
            idex_c  = OP_HOLD;
            exmem_c = OP_HOLD;
        end else if (state == STALL) begin
            ifid_c = OP_HOLD;
            idex_c = OP_BUB;
            st_nxt = st_cnt - 2'd1;
            if (st_cnt <= 2'd1) begin
                state_nxt = RUN;
            end
        end else if (data_haz) begin
            ifid_c = OP_HOLD;
            idex_c = OP_BUB;
            st_nxt = st_load;
            if (st_load != 2'd0) begin
                state_nxt = STALL;
            end
        end else begin
            if (state == MD_BUSY) begin
                md_nxt = md_cnt - 6'd1;
                if (md_cnt <= 6'd1) begin
                    state_nxt = RUN;
                end
            end

            if (md_haz) begin
                ifid_c = OP_HOLD;
                idex_c = OP_BUB;
            end else if (id_is_j) begin
                pc_c   = PC_J;
                ifid_c = OP_BUB;
            end else if (id_is_jr) begin
                pc_c   = PC_JR;
                ifid_c = OP_BUB;
            end else if (id_is_branch) begin
                pc_c   = PC_BR;
                ifid_c = comp_true ? OP_BUB : OP_ADV;
            end

            if ((state == RUN) && id_md_start) begin
                md_nxt    = MD_INIT;
                state_nxt = MD_BUSY;
            end
        end
    end

    // Outputs drop to zero the moment reset asserts, clock or not.
    assign IFIDop  = reset ? ifid_c  : OP_ADV;
    assign IDEXop  = reset ? idex_c  : OP_ADV;
    assign EXMEMop = reset ? exmem_c : OP_ADV;
    assign PCSrc   = reset ? pc_c    : PC_SEQ;
    assign md_busy = reset && (state == MD_BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cycles push expected
// outputs, the sample point pops and compares them.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic       id_is_branch;
        logic       id_is_j;
        logic       id_is_jr;
        logic       comp_true;
        logic       id_md_start;
        logic       id_md_use;
        logic       idex_memread;
        logic       idex_regwrite;
        logic [4:0] idex_dst;
        logic       exmem_memop;
        logic       dmem_ready;
    } stim_t;

    typedef struct packed {
        logic [1:0] ifid;
        logic [1:0] idex;
        logic [1:0] exmem;
        logic [1:0] pc;
        logic       busy;
    } exp_t;

    logic  clk;
    logic  reset;
    stim_t s;
    logic  sel;
    exp_t  q[$];
    int    n_chk;
    int    n_fail;

    logic [1:0] a_ifid, a_idex, a_exmem, a_pc;
    logic       a_busy;
    logic [1:0] b_ifid, b_idex, b_exmem, b_pc;
    logic       b_busy;

    hazard_ctrl #(.MD_LAT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (s.id_rs),
        .id_rt         (s.id_rt),
        .id_uses_rs    (s.id_uses_rs),
        .id_uses_rt    (s.id_uses_rt),
        .id_is_branch  (s.id_is_branch),
        .id_is_j       (s.id_is_j),
        .id_is_jr      (s.id_is_jr),
        .comp_true     (s.comp_true),
        .id_md_start   (s.id_md_start),
        .id_md_use     (s.id_md_use),
        .idex_memread  (s.idex_memread),
        .idex_regwrite (s.idex_regwrite),
        .idex_dst      (s.idex_dst),
        .exmem_memop   (s.exmem_memop),
        .dmem_ready    (s.dmem_ready),
        .IFIDop        (a_ifid),
        .IDEXop        (a_idex),
        .EXMEMop       (a_exmem),
        .PCSrc         (a_pc),
        .md_busy       (a_busy)
    );

    hazard_ctrl #(.MD_LAT(11)) dut2 (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (s.id_rs),
        .id_rt         (s.id_rt),
        .id_uses_rs    (s.id_uses_rs),
        .id_uses_rt    (s.id_uses_rt),
        .id_is_branch  (s.id_is_branch),
        .id_is_j       (s.id_is_j),
        .id_is_jr      (s.id_is_jr),
        .comp_true     (s.comp_true),
        .id_md_start   (s.id_md_start),
        .id_md_use     (s.id_md_use),
        .idex_memread  (s.idex_memread),
        .idex_regwrite (s.idex_regwrite),
        .idex_dst      (s.idex_dst),
        .exmem_memop   (s.exmem_memop),
        .dmem_ready    (s.dmem_ready),
        .IFIDop        (b_ifid),
        .IDEXop        (b_idex),
        .EXMEMop       (b_exmem),
        .PCSrc         (b_pc),
        .md_busy       (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] f, input logic [1:0] d,
                        input logic [1:0] e, input logic [1:0] p,
                        input logic b);
        exp_t x;
        x.ifid  = f;
        x.idex  = d;
        x.exmem = e;
        x.pc    = p;
        x.busy  = b;
        q.push_back(x);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t x;
        exp_t o;
        if (q.size() == 0) begin
            check({tag, ".queue"}, 8'd0, 8'd1);
            return;
        end
        x = q.pop_front();
        o = sel ? {b_ifid, b_idex, b_exmem, b_pc, b_busy}
                : {a_ifid, a_idex, a_exmem, a_pc, a_busy};
        check({tag, ".ifid"},  8'(o.ifid),  8'(x.ifid));
        check({tag, ".idex"},  8'(o.idex),  8'(x.idex));
        check({tag, ".exmem"}, 8'(o.exmem), 8'(x.exmem));
        check({tag, ".pc"},    8'(o.pc),    8'(x.pc));
        check({tag, ".busy"},  8'(o.busy),  8'(x.busy));
    endtask

    // Inputs already set in s; sample at negedge, then advance a cycle.
    task automatic step(input string tag,
                        input logic [1:0] f, input logic [1:0] d,
                        input logic [1:0] e, input logic [1:0] p,
                        input logic b);
        push(f, d, e, p, b);
        @(negedge clk);
        pop_cmp(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        s = '0;
        s.dmem_ready = 1'b1;
    endtask

    task automatic load_use(input logic [4:0] r);
        s.idex_memread  = 1'b1;
        s.idex_regwrite = 1'b1;
        s.idex_dst      = r;
        s.id_rs         = r;
        s.id_uses_rs    = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        sel    = 1'b0;
        reset  = 1'b0;
        clr();
        s.id_is_j = 1'b1;
        load_use(5'd5);
        #2;
        push(0, 0, 0, 0, 0);
        pop_cmp("reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b1;

        clr();
        step("idle", 0, 0, 0, 0, 0);

        // load-use: one bubble then advance
        load_use(5'd5);
        step("lu_stall", 2, 1, 0, 0, 0);
        clr();
        s.id_rs = 5'd5;
        s.id_uses_rs = 1'b1;
        step("lu_after", 0, 0, 0, 0, 0);

        // load feeding a taken branch: two bubbles
        clr();
        s.idex_memread = 1'b1;
        s.idex_dst     = 5'd8;
        s.id_rt        = 5'd8;
        s.id_uses_rt   = 1'b1;
        s.id_is_branch = 1'b1;
        s.comp_true    = 1'b1;
        step("lb_stall0", 2, 1, 0, 0, 0);
        s.idex_memread = 1'b0;
        s.idex_dst     = 5'd0;
        step("lb_stall1", 2, 1, 0, 0, 0);
        step("lb_branch", 1, 0, 0, 1, 0);

        // ALU result feeding jr: one bubble
        clr();
        s.idex_regwrite = 1'b1;
        s.idex_dst      = 5'd3;
        s.id_rs         = 5'd3;
        s.id_uses_rs    = 1'b1;
        s.id_is_jr      = 1'b1;
        step("alu_jr", 2, 1, 0, 0, 0);
        s.idex_regwrite = 1'b0;
        s.idex_dst      = 5'd0;
        step("jr_after", 1, 0, 0, 3, 0);

        clr();
        s.idex_regwrite = 1'b1;
        s.idex_dst      = 5'd3;
        s.id_rs         = 5'd3;
        s.id_uses_rs    = 1'b1;
        step("alu_nohaz", 0, 0, 0, 0, 0);
        clr();
        load_use(5'd0);
        step("r0_nohaz", 0, 0, 0, 0, 0);
        clr();
        load_use(5'd7);
        s.id_uses_rs = 1'b0;
        step("unused_rs", 0, 0, 0, 0, 0);

        clr();
        s.id_is_branch = 1'b1;
        step("br_nt", 0, 0, 0, 1, 0);
        s.id_is_j = 1'b1;
        s.comp_true = 1'b1;
        step("j_over_br", 1, 0, 0, 2, 0);
        s.id_is_jr = 1'b1;
        step("j_over_jr", 1, 0, 0, 2, 0);
        s.id_is_j = 1'b0;
        step("jr_over_br", 1, 0, 0, 3, 0);

        // memwait over a pending load-use
        clr();
        load_use(5'd9);
        s.exmem_memop = 1'b1;
        s.dmem_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("memwait", 2, 2, 2, 0, 0);
        end
        s.dmem_ready = 1'b1;
        step("mw_lu", 2, 1, 0, 0, 0);
        clr();
        step("mw_done", 0, 0, 0, 0, 0);

        // mult/div with MD_LAT=4 and a held consumer
        clr();
        s.id_md_start = 1'b1;
        s.id_md_use   = 1'b1;
        step("md_c0", 0, 0, 0, 0, 0);
        s.id_md_start = 1'b0;
        step("md_c1", 2, 1, 0, 0, 1);
        step("md_c2", 2, 1, 0, 0, 1);
        step("md_c3", 0, 0, 0, 0, 1);
        step("md_c4", 0, 0, 0, 0, 0);

        // jump flows during busy; memwait freezes the count
        clr();
        s.id_md_start = 1'b1;
        step("mdf_c0", 0, 0, 0, 0, 0);
        clr();
        s.id_is_j = 1'b1;
        step("mdf_j", 1, 0, 0, 2, 1);
        clr();
        s.exmem_memop = 1'b1;
        s.dmem_ready  = 1'b0;
        s.id_md_use   = 1'b1;
        step("mdf_mw", 2, 2, 2, 0, 1);
        s.exmem_memop = 1'b0;
        s.dmem_ready  = 1'b1;
        step("mdf_u2", 2, 1, 0, 0, 1);
        step("mdf_u1", 0, 0, 0, 0, 1);
        clr();
        step("mdf_end", 0, 0, 0, 0, 0);

        // async reset while busy with md_cnt=10 (MD_LAT=11 instance)
        clr();
        do_reset();
        sel = 1'b1;
        s.id_md_start = 1'b1;
        step("rb_start", 0, 0, 0, 0, 0);
        clr();
        s.id_is_j = 1'b1;
        push(1, 0, 0, 2, 1);
        @(negedge clk);
        pop_cmp("rb_busy");
        #1;
        reset = 1'b0;
        #1;
        push(0, 0, 0, 0, 0);
        pop_cmp("rb_async");
        @(posedge clk);
        #1;
        reset = 1'b1;
        clr();
        s.id_md_use = 1'b1;
        step("rb_run", 0, 0, 0, 0, 0);
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
